// File: rtl/reg_file_ctrl.sv
// rtl/reg_file_ctrl.sv - command sequencer driving register file select/enable/load and returning read data
// Optional build macro REG_FILE_CTRL_WRITE_ACK_EN: WRITE also returns a response carrying the written data.
module reg_file_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] sel_a,
  output logic [ADDR_W-1:0] sel_b,
  output logic              oe_a,
  output logic              oe_b,
  output logic              ld,
  output logic [DATA_W-1:0] input_bus,
  input  logic [DATA_W-1:0] a_bus,
  input  logic [DATA_W-1:0] b_bus
);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ_A = 2'b01;
  localparam logic [1:0] OP_READ_B = 2'b10;

  typedef enum logic [2:0] {IDLE, LOAD, RD_A, RD_B, CP_RD, CP_LD, RESP} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] dst_q, src_q;
  logic              accept;

  assign accept = (state == IDLE) && cmd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // input_bus is registered so it holds its last load value outside LOAD/CP_LD;
  // the copy value is staged into it on the same edge that captures rsp_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_q     <= '0;
      src_q     <= '0;
      input_bus <= '0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        dst_q <= cmd_dst;
        src_q <= cmd_src;
        if (cmd_op == OP_WRITE) input_bus <= cmd_data;
      end
      case (state)
        RD_A:  rsp_data <= a_bus;
        RD_B:  rsp_data <= b_bus;
        CP_RD: begin
          rsp_data  <= b_bus;
          input_bus <= b_bus;
        end
`ifdef REG_FILE_CTRL_WRITE_ACK_EN
        LOAD:  rsp_data <= input_bus;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    sel_a     = '0;
    sel_b     = '0;
    oe_a      = 1'b0;
    oe_b      = 1'b0;
    ld        = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE:  state_nx = LOAD;
            OP_READ_A: state_nx = RD_A;
            OP_READ_B: state_nx = RD_B;
            default:   state_nx = CP_RD;
          endcase
        end
      end
      LOAD: begin
        sel_a = dst_q;
        ld    = 1'b1;
`ifdef REG_FILE_CTRL_WRITE_ACK_EN
        state_nx = RESP;
`else
        state_nx = IDLE;
`endif
      end
      RD_A: begin
        sel_a    = src_q;
        oe_a     = 1'b1;
        state_nx = RESP;
      end
      RD_B: begin
        sel_b    = src_q;
        oe_b     = 1'b1;
        state_nx = RESP;
      end
      CP_RD: begin
        sel_b    = src_q;
        oe_b     = 1'b1;
        state_nx = CP_LD;
      end
      CP_LD: begin
        sel_a    = dst_q;
        ld       = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
